// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   Issues sequential fetch requests from a program counter, tracks the
//   addresses of outstanding requests, pairs in-order memory responses with
//   those addresses and buffers {pc, instr} in a registered FIFO for decode.
//   A redirect flushes everything. It also counts how many responses are
//   still owed by memory, so that those stale responses are discarded.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   redirect, redirect_pc       flush and restart fetch at redirect_pc
//   imem_req_valid/ready/addr   fetch request channel (valid/ready)
//   imem_rsp_valid/data         in-order responses, no backpressure
//   out_valid/ready             decode channel handshake
//   out_instr, out_pc           oldest buffered instruction and its address
//   out_pc_plus8                out_pc + 2*PC_STEP (wraps)
//   count                       buffered instruction count
//   err                         sticky: response arrived with nothing owed
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDR_W-1:0]       imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [DATA_W-1:0]       imem_rsp_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_instr,
  output logic [ADDR_W-1:0]       out_pc,
  output logic [ADDR_W-1:0]       out_pc_plus8,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] STEP2 = ADDR_W'(2 * PC_STEP);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  // Control state
  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  aq_wr, aq_rd;
  logic [PTR_W-1:0]  fq_wr, fq_rd;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  count_r;
  logic              err_r;

  // Storage (no reset: validity is tracked by the pointers and counters)
  logic [ADDR_W-1:0] aq_addr  [DEPTH];
  logic [ADDR_W-1:0] fq_pc    [DEPTH];
  logic [DATA_W-1:0] fq_instr [DEPTH];

  logic [CNT_W:0]   budget;
  logic             drop_zero;
  logic             accept;
  logic             rsp_take;
  logic             rsp_drop;
  logic             rsp_err;
  logic             deliver;
  logic [CNT_W-1:0] redir_sum;
  logic             redir_cancel;
  logic [CNT_W-1:0] redir_drop;
  logic             redir_err;

  always_comb begin
    // Buffered plus outstanding entries must stay below DEPTH before a new
    // request may issue; this is what bounds FIFO occupancy.
    budget         = {1'b0, count_r} + {1'b0, inflight};
    drop_zero      = (drop_cnt == '0);
    imem_req_valid = reset && !redirect && drop_zero && (budget < DEPTH_C);
    accept         = imem_req_valid && imem_req_ready;
    rsp_take       = reset && !redirect && imem_rsp_valid && drop_zero && (inflight != '0);
    rsp_drop       = reset && !redirect && imem_rsp_valid && !drop_zero;
    rsp_err        = reset && !redirect && imem_rsp_valid && drop_zero && (inflight == '0);
    out_valid      = reset && (count_r != '0);
    deliver        = out_valid && out_ready && !redirect;
    // On redirect every outstanding request becomes a response to discard;
    // a response arriving in the redirect cycle itself is discarded at once.
    // If nothing is owed at all, that response is unsolicited.
    redir_sum      = drop_cnt + inflight;
    redir_cancel   = imem_rsp_valid && (redir_sum != '0);
    redir_err      = imem_rsp_valid && (redir_sum == '0);
    redir_drop     = redir_sum - {{(CNT_W-1){1'b0}}, redir_cancel};
  end

  assign imem_req_addr = fetch_pc;
  assign out_instr     = fq_instr[fq_rd];
  assign out_pc        = fq_pc[fq_rd];
  assign out_pc_plus8  = fq_pc[fq_rd] + STEP2;
  assign count         = count_r;
  assign err           = err_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      aq_wr    <= '0;
      aq_rd    <= '0;
      fq_wr    <= '0;
      fq_rd    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      count_r  <= '0;
      err_r    <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      aq_wr    <= '0;
      aq_rd    <= '0;
      fq_wr    <= '0;
      fq_rd    <= '0;
      inflight <= '0;
      count_r  <= '0;
      drop_cnt <= redir_drop;
      if (redir_err) err_r <= 1'b1;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + STEP;
        aq_wr    <= aq_wr + 1'b1;
      end
      if (rsp_take) begin
        aq_rd <= aq_rd + 1'b1;
        fq_wr <= fq_wr + 1'b1;
      end
      if (deliver) fq_rd <= fq_rd + 1'b1;
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      if (rsp_err) err_r <= 1'b1;
      case ({accept, rsp_take})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      case ({rsp_take, deliver})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Request/response boundary: address queue and registered instruction FIFO
  always_ff @(posedge clk) begin
    if (accept) aq_addr[aq_wr] <= fetch_pc;
    if (rsp_take) begin
      fq_pc[fq_wr]    <= aq_addr[aq_rd];
      fq_instr[fq_wr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 32-bit instance driven by a small
// in-order memory model with configurable latency, plus an 8-bit-address
// instance for PC wrap-around driven by hand.
module tb_fetch_unit;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus8;
  logic [2:0]  count;
  logic        err;

  logic        w_redirect = 1'b0;
  logic [7:0]  w_redirect_pc = '0;
  logic        w_req_valid;
  logic        w_req_ready = 1'b0;
  logic [7:0]  w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b0;
  logic [31:0] w_out_instr;
  logic [7:0]  w_out_pc;
  logic [7:0]  w_out_pc_plus8;
  logic [2:0]  w_count;
  logic        w_err;

  fetch_unit dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus8(out_pc_plus8),
    .count(count), .err(err)
  );

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'hF8)) dut_w (
    .clk(clk), .reset(reset), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_instr(w_out_instr), .out_pc(w_out_pc), .out_pc_plus8(w_out_pc_plus8),
    .count(w_count), .err(w_err)
  );

  typedef struct packed { logic [31:0] addr; int due; } pend_t;
  typedef struct packed { int cyc; logic [31:0] pc; logic [31:0] instr; logic [31:0] pc8; } rec_t;

  pend_t pend[$];
  rec_t  log_q[$];
  int    cyc = 0;
  int    lat = 1;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update memory model after.
  task automatic cycle();
    logic        acc;
    logic        rsp;
    logic [31:0] a;
    #1;
    acc = imem_req_valid && imem_req_ready;
    rsp = imem_rsp_valid;
    a   = imem_req_addr;
    if (out_valid && out_ready)
      log_q.push_back('{cyc: cyc, pc: out_pc, instr: out_instr, pc8: out_pc_plus8});
    @(posedge clk);
    #1;
    cyc++;
    if (rsp && pend.size() > 0) void'(pend.pop_front());
    if (acc) pend.push_back('{addr: a, due: cyc + lat - 1});
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].addr ^ 32'hA5A5_0000;
    end else begin
      imem_rsp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect = 1'b0;
    repeat (4) cycle();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    chk("rst_w_req_valid", w_req_valid, 0);
    pend.delete();
    log_q.delete();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic release_rst();
    reset = 1'b1;
    cyc = 0;
    #1;
    chk("rel_req_valid", imem_req_valid, 1);
    chk("rel_req_addr", imem_req_addr, 0);
  endtask

  task automatic chk_log(input int i, input logic [31:0] pc, input int at_cyc);
    if (i < log_q.size()) begin
      chk("log_pc", log_q[i].pc, pc);
      chk("log_instr", log_q[i].instr, pc ^ 32'hA5A5_0000);
      chk("log_pc8", log_q[i].pc8, pc + 32'd8);
      if (at_cyc >= 0) chk("log_cyc", log_q[i].cyc, at_cyc);
    end else begin
      chk("log_len", log_q.size(), i + 1);
    end
  endtask

  initial begin
    do_reset();

    // Streaming: latency 1, always ready -> one instruction per cycle from cycle 2
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    release_rst();
    repeat (12) cycle();
    chk("stream_n", log_q.size(), 10);
    for (int i = 0; i < 8; i++) chk_log(i, 32'(4 * i), 2 + i);
    chk("stream_err", err, 0);

    // Backpressure: decode stalled for 20 cycles, buffer fills to DEPTH
    do_reset();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
    release_rst();
    repeat (20) cycle();
    chk("bp_count", count, 4);
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_pc", out_pc, 0);
    out_ready = 1'b1;
    repeat (8) cycle();
    for (int i = 0; i < 5; i++) chk_log(i, 32'(4 * i), 20 + i);

    // Redirect with 3 in flight, latency 3; response 0 arrives in redirect cycle
    do_reset();
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
    release_rst();
    repeat (3) cycle();
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    chk("r35_req_in_redir", imem_req_valid, 0);
    cycle();
    redirect = 1'b0;
    #1;
    chk("r35_req_c4", imem_req_valid, 0);
    chk("r35_out_c4", out_valid, 0);
    cycle();
    chk("r35_req_c5", imem_req_valid, 0);
    cycle();
    chk("r35_req_c6", imem_req_valid, 1);
    chk("r35_addr_c6", imem_req_addr, 32'h100);
    repeat (6) cycle();
    chk("r35_n", log_q.size(), 2);
    chk_log(0, 32'h100, 10);
    chk_log(1, 32'h104, 11);
    chk("r35_err", err, 0);

    // Redirect coincident with a response and an out handshake
    do_reset();
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
    release_rst();
    repeat (4) cycle();
    chk("r36_out_valid", out_valid, 1);
    chk("r36_out_pc", out_pc, 0);
    chk("r36_count", count, 1);
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect = 1'b0;
    #1;
    chk("r36_out_valid_n1", out_valid, 0);
    chk("r36_count_n1", count, 0);
    chk("r36_delivered", log_q.size(), 1);
    chk_log(0, 32'h0, 4);
    chk("r36_req_c5", imem_req_valid, 0);
    cycle();
    chk("r36_req_c6", imem_req_valid, 0);
    cycle();
    chk("r36_req_c7", imem_req_valid, 1);
    chk("r36_addr_c7", imem_req_addr, 32'h200);
    repeat (5) cycle();
    chk("r36_n", log_q.size(), 2);
    chk_log(1, 32'h200, 11);

    // Unsolicited response with nothing in flight
    do_reset();
    lat = 1; imem_req_ready = 1'b0; out_ready = 1'b1;
    release_rst();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    cycle();
    chk("err_set", err, 1);
    chk("err_count", count, 0);
    chk("err_out_valid", out_valid, 0);
    repeat (5) cycle();
    chk("err_sticky", err, 1);
    do_reset();

    // PC wrap on the 8-bit instance
    imem_req_ready = 1'b0; w_req_ready = 1'b1; w_out_ready = 1'b0;
    release_rst();
    chk("w_valid_c0", w_req_valid, 1);
    chk("w_addr_c0", w_req_addr, 8'hF8);
    cycle();
    chk("w_addr_c1", w_req_addr, 8'hFC);
    cycle();
    chk("w_addr_c2", w_req_addr, 8'h00);
    cycle();
    chk("w_addr_c3", w_req_addr, 8'h04);
    cycle();
    chk("w_valid_c4", w_req_valid, 0);
    w_rsp_valid = 1'b1; w_rsp_data = 32'h11;
    cycle();
    w_rsp_data = 32'h22;
    #1;
    chk("w_out_valid", w_out_valid, 1);
    chk("w_out_pc0", w_out_pc, 8'hF8);
    chk("w_out_pc8_0", w_out_pc_plus8, 8'h00);
    chk("w_out_instr0", w_out_instr, 32'h11);
    cycle();
    w_rsp_valid = 1'b0; w_out_ready = 1'b1;
    cycle();
    chk("w_out_pc1", w_out_pc, 8'hFC);
    chk("w_out_pc8_1", w_out_pc_plus8, 8'h04);
    chk("w_out_instr1", w_out_instr, 32'h22);
    chk("w_err", w_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, width of the program counter and fetch addresses.
REQ-002 Parameter DATA_W, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, instruction buffer entries; power of two, >= 2.
REQ-004 Parameter PC_STEP, default 4, PC increment per sequential fetch.
REQ-005 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 redirect  in  1  branch/flush request; redirect_pc  in  ADDR_W  new fetch address.
REQ-009 imem_req_valid  out  1; imem_req_ready  in  1; imem_req_addr  out  ADDR_W; fetch request channel.
REQ-010 imem_rsp_valid  in  1; imem_rsp_data  in  DATA_W; in-order responses, no backpressure, latency >= 1 cycle.
REQ-011 out_valid  out  1; out_ready  in  1; out_instr  out  DATA_W; out_pc  out  ADDR_W; out_pc_plus8  out  ADDR_W; decode channel.
REQ-012 count  out  clog2(DEPTH)+1  buffered instruction count; err  out  1  sticky protocol error.

Function
REQ-013 Internal state: fetch PC, in-flight address queue (DEPTH entries), instruction FIFO of {pc, instr} (DEPTH entries), inflight counter, drop counter, err flag.
REQ-014 imem_req_valid SHALL be 1 iff not redirect, drop_cnt == 0, and count + inflight < DEPTH.
REQ-015 imem_req_addr SHALL equal the fetch PC; a request is accepted when imem_req_valid && imem_req_ready.
REQ-016 On acceptance, the fetch PC SHALL advance by PC_STEP (mod 2^ADDR_W, wrap silently), the address SHALL be pushed to the in-flight queue, and inflight SHALL increment.
REQ-017 While valid && !ready, imem_req_addr SHALL remain stable; retraction is permitted only in a redirect cycle.
REQ-018 A response with drop_cnt == 0 and inflight > 0 SHALL pop the in-flight queue and push {popped addr, imem_rsp_data} into the instruction FIFO; inflight decrements.
REQ-019 A response with drop_cnt > 0 SHALL be discarded and drop_cnt SHALL decrement.
REQ-020 A response with drop_cnt == 0 and inflight == 0 SHALL be discarded and set err; err is cleared only by reset.
REQ-021 The FIFO SHALL be registered (no fall-through): a response at cycle M makes its entry visible at out_valid no earlier than M+1.
REQ-022 out_valid = (count > 0); out_instr/out_pc show the oldest entry; out_pc_plus8 = out_pc + 2*PC_STEP, mod 2^ADDR_W.
REQ-023 Entry is consumed on out_valid && out_ready; push and pop in the same cycle leave count unchanged.
REQ-024 Occupancy never exceeds DEPTH by construction (REQ-014); the count + inflight budget SHALL be checked every cycle.
REQ-025 Redirect at cycle N: the FIFO and in-flight queue SHALL be flushed, the fetch PC SHALL become redirect_pc, and drop_cnt SHALL become drop_cnt + inflight - (imem_rsp_valid ? 1 : 0), with any same-cycle response discarded.
REQ-026 A consume handshake in the redirect cycle SHALL count as delivered; out_valid SHALL be 0 at N+1.
REQ-027 First request to redirect_pc SHALL present at N+1 if drop_cnt == 0, else in the cycle after drop_cnt reaches 0.
REQ-028 Back-to-back redirects: the last one wins; drop accounting SHALL accumulate per REQ-025.
REQ-029 With ready always 1, 1-cycle memory latency and out_ready always 1, throughput SHALL be one instruction per cycle.

Reset
REQ-030 While reset == 0 at a rising edge: fetch PC = RESET_PC; count, inflight, drop_cnt = 0; err = 0; both queues empty.
REQ-031 Outputs in reset: imem_req_valid = 0, out_valid = 0; request valid asserts in the first cycle after reset is released, with addr RESET_PC.
REQ-032 Reset mid-operation SHALL abandon all in-flight and buffered state; later responses for abandoned requests are treated per REQ-020.

Verification
REQ-033 Streaming: RESET_PC=0, ready=1, latency 1, out_ready=1 -> out_pc 0,4,8,... on consecutive cycles; out_pc_plus8 = out_pc+8.
REQ-034 Backpressure: out_ready=0 for 20 cycles -> count saturates at 4, imem_req_valid=0, no data lost; on release, order 0,4,8,12,16.
REQ-035 Redirect with 3 in flight, latency 3, redirect_pc=0x100 -> 3 responses dropped, next out_pc = 0x100, no stale instr delivered.
REQ-036 Redirect coincident with response and out handshake -> response dropped, handshaken entry counted once, drop_cnt = inflight-1.
REQ-037 Unsolicited imem_rsp_valid with inflight=0 -> err=1, held until reset; count unchanged.
REQ-038 PC wrap: ADDR_W=8, RESET_PC=0xF8 -> fetch addrs 0xF8, 0xFC, 0x00; out_pc_plus8 for 0xFC = 0x04.
